// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and sizing helpers for the nibble-serial adder.
package nibble_serial_adder_pkg;

  // Sequencer states (2-bit encoding).
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Width of the carry-lookahead slice; the slice adder is hard-wired to 4 bits.
  localparam int SLICE_W = 4;

  // Number of slice passes needed for a WIDTH-bit operand.
  function automatic int nslices(input int width);
    return width / SLICE_W;
  endfunction

  // Nibble index width, never narrower than one bit (WIDTH == SLICE_W case).
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/nibble_serial_adder_cla.sv
// 4-bit generate/propagate carry-lookahead adder slice, purely combinational.
// Also exposes the carry into bit 3 so the sequencer can derive signed overflow.
module nibble_cla
  import nibble_serial_adder_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               ci,
  output logic [SLICE_W-1:0] s,
  output logic               co,
  output logic               c3
);

  logic [SLICE_W-1:0] g;
  logic [SLICE_W-1:0] p;
  logic [SLICE_W:0]   c;

  // Flattened lookahead equations: every carry depends only on g, p and ci.
  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & ci);
    s    = p ^ c[SLICE_W-1:0];
    co   = c[4];
    c3   = c[3];
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: latches operands on start, then pushes one nibble
// per cycle (LSB first) through a single CLA slice, chaining the carry.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | waiting for start; result registers hold the last answer
//   ST_RUN  | one nibble added per cycle, idx_q selects the nibble
//   ST_DONE | result complete, done pulses for this single cycle
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NSLICES = nslices(WIDTH);
  localparam int IDX_W   = idx_w(NSLICES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NSLICES - 1);

  // Reject parameterisations the single fixed slice cannot serve.
  if ((SLICE != SLICE_W) || (WIDTH < SLICE) || ((WIDTH % SLICE) != 0)) begin : g_bad_param
    $error("nibble_serial_adder: WIDTH must be a positive multiple of SLICE and SLICE must be 4");
  end

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               carry_q, carry_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  logic [SLICE-1:0]   a_nib;
  logic [SLICE-1:0]   b_nib;
  logic [SLICE-1:0]   s_nib;
  logic               co_nib;
  logic               c3_nib;
  logic               last_nib;

  assign last_nib = (idx_q == IDX_LAST);

  // Select the current operand nibbles with an explicit decode of idx_q.
  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int i = 0; i < NSLICES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_nib = a_q[i*SLICE +: SLICE];
        b_nib = b_q[i*SLICE +: SLICE];
      end
    end
  end

  nibble_cla u_cla (
    .a  (a_nib),
    .b  (b_nib),
    .ci (carry_q),
    .s  (s_nib),
    .co (co_nib),
    .c3 (c3_nib)
  );

  // State register; reset wins over any concurrent start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start)    state_d = ST_RUN;
      ST_RUN:  if (last_nib) state_d = ST_DONE;
      ST_DONE:               state_d = ST_IDLE;
      default:               state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from state; done is a single-cycle pulse by construction.
  always_comb begin
    busy = (state_q == ST_RUN) || (state_q == ST_DONE);
    done = (state_q == ST_DONE);
    sum  = sum_q;
    cout = cout_q;
    ovf  = ovf_q;
  end

  // Datapath next values: operand capture, nibble write-back, carry chaining.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
        end
      end
      ST_RUN: begin
        carry_d = co_nib;
        idx_d   = idx_q + IDX_W'(1);
        for (int i = 0; i < NSLICES; i++) begin
          if (idx_q == IDX_W'(i)) begin
            sum_d[i*SLICE +: SLICE] = s_nib;
          end
        end
        if (last_nib) begin
          cout_d = co_nib;
          ovf_d  = c3_nib ^ co_nib;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; a mid-run reset discards the partial result entirely.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule
